// File: rtl/ysyx_25040111_clint_timer.sv
// CLINT-style machine timer (mtime/mtimecmp) with an AXI4-Lite-like slave port.
// Define CLINT_MSIP_EN to add the per-hart software-interrupt (msip) registers.
module ysyx_25040111_clint_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          NHART     = 1,
  parameter int          DIV       = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  input  logic [31:0]       awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic [NHART-1:0]  mtip,
  output logic [NHART-1:0]  msip,
  output logic              dbg_r_state,
  output logic [1:0]        dbg_w_state
);

  // Handshake rule on every channel: a beat transfers on the rising edge where
  // valid and ready are both high; valid and its payload stay stable until then.

  typedef enum logic {R_IDLE, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_e;
  typedef enum logic [2:0] {K_NONE, K_MTIME_LO, K_MTIME_HI, K_CMP_LO, K_CMP_HI, K_MSIP} kind_e;

  typedef struct packed {
    kind_e      kind;
    logic [1:0] hart;
  } dec_t;

  localparam logic [31:0] CMP_END = 32'h4000 + 32'(8 * NHART);
`ifdef CLINT_MSIP_EN
  localparam logic [31:0] MSIP_END = 32'(4 * NHART);
`endif

  function automatic dec_t decode(input logic [31:0] addr);
    logic [31:0] off;
    dec_t d;
    off    = addr - BASE_ADDR;
    d.kind = K_NONE;
    d.hart = '0;
    if (off[1:0] == 2'b00) begin
      if (off == 32'h48) begin
        d.kind = K_MTIME_LO;
      end else if (off == 32'h4C) begin
        d.kind = K_MTIME_HI;
      end else if (off >= 32'h4000 && off < CMP_END) begin
        d.kind = off[2] ? K_CMP_HI : K_CMP_LO;
        d.hart = off[4:3];
      end
`ifdef CLINT_MSIP_EN
      else if (off < MSIP_END) begin
        d.kind = K_MSIP;
        d.hart = off[3:2];
      end
`endif
    end
    return d;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  // Timer state
  logic [63:0]      mtime_q, mtime_d;
  logic [7:0]       presc_q, presc_d;
  logic [63:0]      cmp_q [NHART];
  logic [63:0]      cmp_d [NHART];
  logic [NHART-1:0] mtip_q, mtip_d;
  logic             tick;

  // Read channel state
  r_state_e    r_state_q, r_state_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  dec_t        rd_dec;
  logic [31:0] rd_val;
  logic        rd_err;

  // Write channel state
  w_state_e    w_state_q, w_state_d;
  logic        aw_got_q, aw_got_d;
  logic        w_got_q, w_got_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  bresp_q, bresp_d;
  dec_t        wr_dec;
  logic        wr_en;
  logic        wr_err;

`ifdef CLINT_MSIP_EN
  logic [NHART-1:0] msip_q, msip_d;
`endif

  assign arready     = (r_state_q == R_IDLE);
  assign rvalid      = (r_state_q == R_RESP);
  assign rdata       = rdata_q;
  assign rresp       = rresp_q;
  assign awready     = (w_state_q == W_IDLE) && !aw_got_q;
  assign wready      = (w_state_q == W_IDLE) && !w_got_q;
  assign bvalid      = (w_state_q == W_RESP);
  assign bresp       = bresp_q;
  assign mtip        = mtip_q;
  assign dbg_r_state = r_state_q;
  assign dbg_w_state = w_state_q;

`ifdef CLINT_MSIP_EN
  assign msip = msip_q;
`else
  assign msip = '0;
`endif

  // Read decode: data is captured in the address-handshake cycle.
  always_comb begin
    rd_dec = decode(araddr);
    rd_val = '0;
    rd_err = 1'b0;
    case (rd_dec.kind)
      K_MTIME_LO: rd_val = mtime_q[31:0];
      K_MTIME_HI: rd_val = mtime_q[63:32];
      K_CMP_LO: begin
        for (int h = 0; h < NHART; h++) begin
          if (rd_dec.hart == 2'(h)) rd_val = cmp_q[h][31:0];
        end
      end
      K_CMP_HI: begin
        for (int h = 0; h < NHART; h++) begin
          if (rd_dec.hart == 2'(h)) rd_val = cmp_q[h][63:32];
        end
      end
`ifdef CLINT_MSIP_EN
      K_MSIP: begin
        for (int h = 0; h < NHART; h++) begin
          if (rd_dec.hart == 2'(h)) rd_val = {31'b0, msip_q[h]};
        end
      end
`endif
      default: rd_err = 1'b1;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (arvalid) begin
          rdata_d   = rd_val;
          rresp_d   = rd_err ? 2'b10 : 2'b00;
          r_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // AW and W beats are collected independently; execution starts once both are held.
  always_comb begin
    w_state_d = w_state_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (awvalid && awready) begin
          aw_got_d = 1'b1;
          awaddr_d = awaddr;
        end
        if (wvalid && wready) begin
          w_got_d = 1'b1;
          wdata_d = wdata;
          wstrb_d = wstrb;
        end
        if (aw_got_d && w_got_d) w_state_d = W_EXEC;
      end
      W_EXEC: begin
        bresp_d   = wr_err ? 2'b10 : 2'b00;
        aw_got_d  = 1'b0;
        w_got_d   = 1'b0;
        w_state_d = W_RESP;
      end
      W_RESP: begin
        if (bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Counter and register updates; a software write to mtime overrides that cycle's tick.
  always_comb begin
    wr_dec  = decode(awaddr_q);
    wr_en   = (w_state_q == W_EXEC);
    wr_err  = (wr_dec.kind == K_NONE);
    tick    = (presc_q == 8'(DIV - 1));
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    presc_d = tick ? 8'd0 : presc_q + 8'd1;
    for (int h = 0; h < NHART; h++) cmp_d[h] = cmp_q[h];
`ifdef CLINT_MSIP_EN
    msip_d = msip_q;
`endif
    if (wr_en) begin
      case (wr_dec.kind)
        K_MTIME_LO: begin
          mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], wdata_q, wstrb_q)};
          presc_d = 8'd0;
        end
        K_MTIME_HI: begin
          mtime_d = {merge(mtime_q[63:32], wdata_q, wstrb_q), mtime_q[31:0]};
          presc_d = 8'd0;
        end
        K_CMP_LO: begin
          for (int h = 0; h < NHART; h++) begin
            if (wr_dec.hart == 2'(h))
              cmp_d[h] = {cmp_q[h][63:32], merge(cmp_q[h][31:0], wdata_q, wstrb_q)};
          end
        end
        K_CMP_HI: begin
          for (int h = 0; h < NHART; h++) begin
            if (wr_dec.hart == 2'(h))
              cmp_d[h] = {merge(cmp_q[h][63:32], wdata_q, wstrb_q), cmp_q[h][31:0]};
          end
        end
`ifdef CLINT_MSIP_EN
        K_MSIP: begin
          for (int h = 0; h < NHART; h++) begin
            if (wr_dec.hart == 2'(h) && wstrb_q[0]) msip_d[h] = wdata_q[0];
          end
        end
`endif
        default: ;
      endcase
    end
    for (int h = 0; h < NHART; h++) mtip_d[h] = (mtime_q >= cmp_q[h]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_q   <= '0;
      presc_q   <= '0;
      mtip_q    <= '0;
      for (int h = 0; h < NHART; h++) cmp_q[h] <= '1;
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= '0;
      w_state_q <= W_IDLE;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= '0;
    end else begin
      mtime_q   <= mtime_d;
      presc_q   <= presc_d;
      mtip_q    <= mtip_d;
      for (int h = 0; h < NHART; h++) cmp_q[h] <= cmp_d[h];
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      w_state_q <= w_state_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
    end
  end

`ifdef CLINT_MSIP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) msip_q <= '0;
    else        msip_q <= msip_d;
  end
`endif

endmodule

// File: doc/ysyx_25040111_clint_timer.md
YSYX_25040111_CLINT_TIMER -- requirements
Module: ysyx_25040111_clint_timer

Interface
REQ-001 Parameters: BASE_ADDR, 32'h02000000, region base; NHART, 1, hart count (1..4); DIV, 1, clk cycles per mtime tick (1..255).
REQ-002 clk  in  1  clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 araddr/arvalid/arready  in/in/out  32/1/1  read-address channel.
REQ-005 rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read-data channel.
REQ-006 awaddr/awvalid/awready  in/in/out  32/1/1  write-address channel.
REQ-007 wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write-data channel.
REQ-008 bresp/bvalid/bready  out/out/in  2/1/1  write-response channel.
REQ-009 mtip  out  NHART  per-hart timer interrupt, registered.
REQ-010 msip  out  NHART  per-hart software interrupt (see REQ-030).

Function
REQ-011 Map (offsets from BASE_ADDR): mtime lo 0x48, hi 0x4C; mtimecmp[h] lo 0x4000+8h, hi 0x4004+8h; msip[h] 0x0000+4h.
REQ-012 64-bit mtime increments by 1 every DIV clk cycles via 8-bit prescaler; wraps 2^64-1 -> 0 silently.
REQ-013 Read FSM states R_IDLE, R_RESP; arready = 1 only in R_IDLE.
REQ-014 arvalid&arready: register decoded data into rdata, go R_RESP, rvalid = 1 next cycle (1-cycle latency).
REQ-015 rdata/rvalid held stable until rvalid&rready, then R_IDLE; back-to-back reads yield one transfer per 2 cycles.
REQ-016 mtime read returns value at address-handshake cycle; lo/hi reads are not atomic.
REQ-017 Write FSM states W_IDLE, W_EXEC, W_RESP; awready/wready = 1 while respective beat not yet latched in W_IDLE.
REQ-018 AW and W accepted independently in any order or same cycle; both latched -> W_EXEC, register updated per wstrb byte lanes, then W_RESP with bvalid = 1 until bvalid&bready.
REQ-019 rresp/bresp = 2'b00 for mapped addresses, 2'b10 for unmapped or hart index >= NHART; unmapped writes change nothing; unmapped reads return 0.
REQ-020 Software write to mtime in same cycle as tick: written bytes take write value, tick discarded that cycle; prescaler restarts at 0.
REQ-021 mtip[h] = (mtime >= mtimecmp[h]), unsigned 64-bit, registered one cycle after either operand changes.
REQ-022 Read and write channels operate concurrently; write visible to reads accepted in cycles after W_EXEC.
REQ-023 Unaligned addresses (addr[1:0] != 0) treated as unmapped.

Reset
REQ-024 rst_n low: mtime = 0, prescaler = 0, mtimecmp[*] = 64'hFFFF_FFFF_FFFF_FFFF, msip = 0.
REQ-025 rst_n low: arready = 1, awready = 1, wready = 1, rvalid = 0, bvalid = 0, rdata = 0, rresp = 0, bresp = 0, mtip = 0, both FSMs IDLE.
REQ-026 Reset mid-transaction aborts it; no response issued afterwards.
REQ-027 After rst_n release, first mtime tick occurs DIV cycles later.

Configuration
REQ-028 Macro CLINT_MSIP_EN controls software-interrupt registers.
REQ-029 Defined: msip[h] bit0 read/write at 0x4h, msip output = register.
REQ-030 Undefined: msip offsets unmapped (SLVERR), msip output tied 0.

Verification
REQ-031 Reset, DIV=1, read 0x48 at cycle 10 after reset -> rvalid 1 cycle after handshake, rdata = 9 or 10 consistently with REQ-016, rresp 00.
REQ-032 DIV=4: sample mtime at t and t+40 cycles -> difference exactly 10.
REQ-033 Write mtimecmp[0] = 100 (lo, hi=0), mtime passing 99 -> 100: mtip[0] rises one cycle after mtime = 100; write mtimecmp[0] hi = 1 -> mtip[0] falls.
REQ-034 W beat 3 cycles before AW, wstrb=4'b0011 wdata=32'hAABBCCDD to mtimecmp[0] lo -> low halfword = CCDD, upper unchanged, bvalid held while bready=0 for 5 cycles, bresp 00.
REQ-035 Read 0x1000 and NHART=1 write mtimecmp[1] -> rresp/bresp = 10, no state change; with CLINT_MSIP_EN write msip[0]=1 -> msip[0]=1, without -> SLVERR, msip=0.
REQ-036 Assert rst_n low while rvalid=1 -> rvalid 0 immediately, mtime 0, mtimecmp all-ones.
